// File: rtl/ndc_pkg.sv
// Shared widths, vector typedefs, camera-update states and a saturation helper
// for the world->camera/NDC vertex stream.
package ndc_pkg;

  localparam int C_WIDTH_DEF = 18;
  localparam int P_WIDTH_DEF = 16;
  localparam int V_WIDTH_DEF = 16;

  typedef logic signed [2:0][P_WIDTH_DEF-1:0] vec3_p_t;
  typedef logic signed [2:0][C_WIDTH_DEF-1:0] vec3_c_t;
  typedef logic signed [2:0][V_WIDTH_DEF-1:0] vec3_v_t;

  typedef enum logic {CAM_IDLE, CAM_PEND} cam_state_t;

  function automatic int p_cam_w(input int c_width);
    return c_width + 1;
  endfunction

  function automatic int dot_w(input int c_width, input int v_width, input int frac_bits);
    return c_width + 1 + v_width - frac_bits + 2;
  endfunction

  // Clamp a wide signed value into the range of a width-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val, input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (val > max_v) return max_v;
    if (val < min_v) return min_v;
    return val;
  endfunction

endpackage

// File: rtl/dot3_pipe.sv
// Two-stage stall-enabled signed 3-element dot product: registered products,
// then registered sum shifted right by FRAC_BITS and truncated to OUT_W.
module dot3_pipe #(
  parameter int A_W       = 19,
  parameter int B_W       = 16,
  parameter int FRAC_BITS = 14,
  parameter int OUT_W     = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [3*A_W-1:0]        a,
  input  logic [3*B_W-1:0]        b,
  output logic signed [OUT_W-1:0] dot,
  output logic signed [OUT_W-1:0] dot_next
);

  localparam int PROD_W = A_W + B_W;
  localparam int SUM_W  = PROD_W + 2;

  logic signed [PROD_W-1:0] prod [3];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) prod[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 3; i++)
        prod[i] <= PROD_W'($signed(a[i*A_W +: A_W])) * PROD_W'($signed(b[i*B_W +: B_W]));
    end
  end

  // dot_next is exposed so the parent can register flags derived from the sum
  // on the same edge as the result itself.
  always_comb begin
    sum      = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]);
    sum_sh   = sum >>> FRAC_BITS;
    dot_next = sum_sh[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) dot <= '0;
    else if (en) dot <= dot_next;
  end

endmodule

// File: rtl/v_to_ndc_stream.sv
// Streaming vertex transform P_cam = P - C dotted with u/v/n, with backpressure,
// shadowed camera updates, optional viewport scaling and a near-plane flag.
module v_to_ndc_stream
  import ndc_pkg::*;
#(
  parameter int C_WIDTH   = 18,
  parameter int P_WIDTH   = 16,
  parameter int V_WIDTH   = 16,
  parameter int FRAC_BITS = 14,
  parameter int TAG_WIDTH = 8,
  parameter int MODE      = 0,
  parameter int SCALE_X   = 16384,
  parameter int SCALE_Y   = 16384,
  parameter int NEAR_Z    = 0,
  localparam int DOT_W    = dot_w(C_WIDTH, V_WIDTH, FRAC_BITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cam_load,
  input  logic [3*C_WIDTH-1:0]    cam_C,
  input  logic [3*V_WIDTH-1:0]    cam_u,
  input  logic [3*V_WIDTH-1:0]    cam_v,
  input  logic [3*V_WIDTH-1:0]    cam_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [3*P_WIDTH-1:0]    s_P,
  input  logic [TAG_WIDTH-1:0]    s_tag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [DOT_W-1:0] m_x,
  output logic signed [DOT_W-1:0] m_y,
  output logic signed [DOT_W-1:0] m_z,
  output logic                    m_behind,
  output logic [TAG_WIDTH-1:0]    m_tag
);

  localparam int PC_W = p_cam_w(C_WIDTH);
  localparam logic signed [DOT_W-1:0] NEAR_T = DOT_W'(NEAR_Z);

  cam_state_t cam_state;
  logic [3*C_WIDTH-1:0] act_C, pend_C;
  logic [3*V_WIDTH-1:0] act_u, act_v, act_n, pend_u, pend_v, pend_n;

  logic stall, en, accept, cam_pend, tail_busy, drained;
  logic v1, v2, v3, behind3;
  logic [TAG_WIDTH-1:0] tag1, tag2, tag3;
  logic [3*PC_W-1:0] pc;
  logic signed [DOT_W-1:0] dot_x, dot_y, dot_z;
  logic signed [DOT_W-1:0] dot_x_next, dot_y_next, dot_z_next;
  logic unused_next;

  assign cam_pend    = (cam_state == CAM_PEND);
  assign stall       = m_valid && !m_ready;
  assign en          = !stall;
  assign s_ready     = !rst && !stall && !cam_pend;
  assign accept      = s_valid && s_ready;
  assign drained     = !v1 && !v2 && !v3 && !tail_busy;
  assign unused_next = ^{dot_x_next, dot_y_next};

  // The active set only changes with the pipe empty, so every vertex sees one camera.
  always_ff @(posedge clk) begin
    if (rst) begin
      cam_state <= CAM_IDLE;
      act_C  <= '0; act_u  <= '0; act_v  <= '0; act_n  <= '0;
      pend_C <= '0; pend_u <= '0; pend_v <= '0; pend_n <= '0;
    end else begin
      case (cam_state)
        CAM_IDLE: if (cam_load) begin
          pend_C <= cam_C; pend_u <= cam_u; pend_v <= cam_v; pend_n <= cam_n;
          cam_state <= CAM_PEND;
        end
        CAM_PEND: if (cam_load) begin
          pend_C <= cam_C; pend_u <= cam_u; pend_v <= cam_v; pend_n <= cam_n;
        end else if (drained) begin
          act_C <= pend_C; act_u <= pend_u; act_v <= pend_v; act_n <= pend_n;
          cam_state <= CAM_IDLE;
        end
        default: cam_state <= CAM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; behind3 <= 1'b0;
      tag1 <= '0; tag2 <= '0; tag3 <= '0;
      pc <= '0;
    end else if (en) begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      tag1 <= s_tag;
      tag2 <= tag1;
      tag3 <= tag2;
      behind3 <= (dot_z_next <= NEAR_T);
      for (int i = 0; i < 3; i++)
        pc[i*PC_W +: PC_W] <= PC_W'($signed(s_P[i*P_WIDTH +: P_WIDTH]))
                            - PC_W'($signed(act_C[i*C_WIDTH +: C_WIDTH]));
    end
  end

  dot3_pipe #(.A_W(PC_W), .B_W(V_WIDTH), .FRAC_BITS(FRAC_BITS), .OUT_W(DOT_W)) u_dot_x (
    .clk(clk), .rst(rst), .en(en), .a(pc), .b(act_u), .dot(dot_x), .dot_next(dot_x_next));
  dot3_pipe #(.A_W(PC_W), .B_W(V_WIDTH), .FRAC_BITS(FRAC_BITS), .OUT_W(DOT_W)) u_dot_y (
    .clk(clk), .rst(rst), .en(en), .a(pc), .b(act_v), .dot(dot_y), .dot_next(dot_y_next));
  dot3_pipe #(.A_W(PC_W), .B_W(V_WIDTH), .FRAC_BITS(FRAC_BITS), .OUT_W(DOT_W)) u_dot_z (
    .clk(clk), .rst(rst), .en(en), .a(pc), .b(act_n), .dot(dot_z), .dot_next(dot_z_next));

  if (MODE == 1) begin : g_scale
    localparam logic signed [63:0] SX = 64'(SCALE_X);
    localparam logic signed [63:0] SY = 64'(SCALE_Y);
    logic signed [63:0] x_sat, y_sat;
    logic v4, behind4;
    logic [TAG_WIDTH-1:0] tag4;
    logic signed [DOT_W-1:0] x4, y4, z4;

    always_comb begin
      x_sat = sat_signed((64'(dot_x) * SX) >>> FRAC_BITS, DOT_W);
      y_sat = sat_signed((64'(dot_y) * SY) >>> FRAC_BITS, DOT_W);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v4 <= 1'b0; behind4 <= 1'b0; tag4 <= '0;
        x4 <= '0; y4 <= '0; z4 <= '0;
      end else if (en) begin
        v4 <= v3; behind4 <= behind3; tag4 <= tag3;
        x4 <= x_sat[DOT_W-1:0];
        y4 <= y_sat[DOT_W-1:0];
        z4 <= dot_z;
      end
    end

    assign m_valid = v4;  assign m_x = x4;  assign m_y = y4;  assign m_z = z4;
    assign m_behind = behind4;  assign m_tag = tag4;  assign tail_busy = v4;
  end else begin : g_direct
    assign m_valid = v3;  assign m_x = dot_x;  assign m_y = dot_y;  assign m_z = dot_z;
    assign m_behind = behind3;  assign m_tag = tag3;  assign tail_busy = 1'b0;
  end

endmodule

// File: tb/tb_v_to_ndc_stream.sv
// Scoreboard bench: one MODE=0 instance plus two MODE=1 instances (x2 scale and a
// deliberately huge scale to reach saturation), all sharing the camera inputs.
module tb_v_to_ndc_stream;

  localparam int DW = 23;
  localparam int PW = 16;
  localparam int CW = 18;
  localparam int VW = 16;
  localparam longint SAT_MAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (DW - 1));

  typedef struct {
    longint x; longint y; longint z;
    logic behind; logic [7:0] tag; int accept_cycle;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  logic clk = 1'b0;
  logic rst;
  logic cam_load;
  logic [3*CW-1:0] cam_C;
  logic [3*VW-1:0] cam_u, cam_v, cam_n;
  logic s_valid0, s_valid1, s_ready0, s_ready1, s_ready2;
  logic [3*PW-1:0] s_P0, s_P1;
  logic [7:0] s_tag0, s_tag1, m_tag0, m_tag1, m_tag2;
  logic m_valid0, m_valid1, m_valid2, m_ready0, m_ready1;
  logic signed [DW-1:0] m_x0, m_y0, m_z0, m_x1, m_y1, m_z1, m_x2, m_y2, m_z2;
  logic m_behind0, m_behind1, m_behind2;

  int cycle = 0;
  int assert_count = 0;
  int fail_count = 0;
  logic latency_check = 1'b0;
  logic seen0 = 1'b0, seen1 = 1'b0;
  int mC[3], mU[3], mV[3], mN[3];
  int pC[3], pU[3], pV[3], pN[3];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  v_to_ndc_stream #(.MODE(0)) dut0 (
    .clk(clk), .rst(rst), .cam_load(cam_load), .cam_C(cam_C), .cam_u(cam_u), .cam_v(cam_v),
    .cam_n(cam_n), .s_valid(s_valid0), .s_ready(s_ready0), .s_P(s_P0), .s_tag(s_tag0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_x(m_x0), .m_y(m_y0), .m_z(m_z0),
    .m_behind(m_behind0), .m_tag(m_tag0));

  v_to_ndc_stream #(.MODE(1), .SCALE_X(32768), .SCALE_Y(16384)) dut1 (
    .clk(clk), .rst(rst), .cam_load(cam_load), .cam_C(cam_C), .cam_u(cam_u), .cam_v(cam_v),
    .cam_n(cam_n), .s_valid(s_valid1), .s_ready(s_ready1), .s_P(s_P1), .s_tag(s_tag1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_x(m_x1), .m_y(m_y1), .m_z(m_z1),
    .m_behind(m_behind1), .m_tag(m_tag1));

  v_to_ndc_stream #(.MODE(1), .SCALE_X(1 << 30), .SCALE_Y(16384)) dut2 (
    .clk(clk), .rst(rst), .cam_load(cam_load), .cam_C(cam_C), .cam_u(cam_u), .cam_v(cam_v),
    .cam_n(cam_n), .s_valid(s_valid1), .s_ready(s_ready2), .s_P(s_P1), .s_tag(s_tag1),
    .m_valid(m_valid2), .m_ready(m_ready1), .m_x(m_x2), .m_y(m_y2), .m_z(m_z2),
    .m_behind(m_behind2), .m_tag(m_tag2));

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint satModel(input longint v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  // Reference transform against the camera the next accepted vertex will see.
  function automatic exp_t makeExp(input int px, input int py, input int pz, input logic [7:0] tag,
                                   input bit scaled, input longint sx, input longint sy);
    exp_t e;
    longint pc[3];
    longint d[3];
    longint s;
    logic signed [DW-1:0] t;
    pc[0] = longint'(px) - mC[0];
    pc[1] = longint'(py) - mC[1];
    pc[2] = longint'(pz) - mC[2];
    for (int k = 0; k < 3; k++) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        s += pc[i] * longint'(k == 0 ? mU[i] : (k == 1 ? mV[i] : mN[i]));
      t = DW'(s >>> 14);
      d[k] = t;
    end
    e.x = scaled ? satModel((d[0] * sx) >>> 14) : d[0];
    e.y = scaled ? satModel((d[1] * sy) >>> 14) : d[1];
    e.z = d[2];
    e.behind = (d[2] <= 0);
    e.tag = tag;
    e.accept_cycle = 0;
    return e;
  endfunction

  task automatic setCamInputs(input int cx, input int cy, input int cz,
                              input int ux, input int uy, input int uz,
                              input int vx, input int vy, input int vz,
                              input int nx, input int ny, input int nz);
    cam_C = {CW'(cz), CW'(cy), CW'(cx)};
    cam_u = {VW'(uz), VW'(uy), VW'(ux)};
    cam_v = {VW'(vz), VW'(vy), VW'(vx)};
    cam_n = {VW'(nz), VW'(ny), VW'(nx)};
    pC = '{cx, cy, cz}; pU = '{ux, uy, uz}; pV = '{vx, vy, vz}; pN = '{nx, ny, nz};
  endtask

  task automatic commitModelCam();
    mC = pC; mU = pU; mV = pV; mN = pN;
  endtask

  task automatic loadCamera(input int cx, input int cy, input int cz,
                            input int ux, input int uy, input int uz,
                            input int vx, input int vy, input int vz,
                            input int nx, input int ny, input int nz);
    setCamInputs(cx, cy, cz, ux, uy, uz, vx, vy, vz, nx, ny, nz);
    cam_load = 1'b1;
    @(posedge clk); #1;
    cam_load = 1'b0;
    commitModelCam();
  endtask

  task automatic applyStimulus(input int px, input int py, input int pz, input logic [7:0] tag,
                               input logic load_cam);
    int guard = 0;
    logic acc = 1'b0;
    exp_t e;
    s_valid0 = 1'b1;
    s_P0 = {PW'(pz), PW'(py), PW'(px)};
    s_tag0 = tag;
    cam_load = load_cam;
    while (!acc && guard < 200) begin
      @(negedge clk);
      if (s_ready0) begin
        acc = 1'b1;
        e = makeExp(px, py, pz, tag, 1'b0, 0, 0);
        e.accept_cycle = cycle + 1;
        q0.push_back(e);
      end
      @(posedge clk); #1;
      guard++;
    end
    s_valid0 = 1'b0;
    cam_load = 1'b0;
    if (load_cam) commitModelCam();
    if (!acc) checkOutput("accept_timeout_dut0", 0, 1);
  endtask

  task automatic applyStimulus1(input int px, input int py, input int pz, input logic [7:0] tag);
    int guard = 0;
    logic acc = 1'b0;
    exp_t e;
    s_valid1 = 1'b1;
    s_P1 = {PW'(pz), PW'(py), PW'(px)};
    s_tag1 = tag;
    while (!acc && guard < 200) begin
      @(negedge clk);
      if (s_ready1) begin
        acc = 1'b1;
        e = makeExp(px, py, pz, tag, 1'b1, 32768, 16384);
        e.accept_cycle = cycle + 1;
        q1.push_back(e);
        e = makeExp(px, py, pz, tag, 1'b1, longint'(1) <<< 30, 16384);
        q2.push_back(e);
      end
      @(posedge clk); #1;
      guard++;
    end
    s_valid1 = 1'b0;
    if (!acc) checkOutput("accept_timeout_dut1", 0, 1);
  endtask

  task automatic waitDrain();
    int g = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    checkOutput("drain_pending_entries", q0.size() + q1.size() + q2.size(), 0);
  endtask

  // Compare the head of each queue whenever its DUT shows valid; pop on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (m_valid0) begin
        if (q0.size() == 0) checkOutput("dut0_unexpected_valid", 1, 0);
        else begin
          e = q0[0];
          checkOutput("dut0_x", m_x0, e.x);
          checkOutput("dut0_y", m_y0, e.y);
          checkOutput("dut0_z", m_z0, e.z);
          checkOutput("dut0_behind", m_behind0, e.behind);
          checkOutput("dut0_tag", m_tag0, e.tag);
          if (latency_check && !seen0) checkOutput("dut0_latency", cycle - e.accept_cycle + 1, 3);
          seen0 = 1'b1;
          if (m_ready0) begin void'(q0.pop_front()); seen0 = 1'b0; end
        end
      end
      if (m_valid1) begin
        if (q1.size() == 0) checkOutput("dut1_unexpected_valid", 1, 0);
        else begin
          e = q1.pop_front();
          checkOutput("dut1_x", m_x1, e.x);
          checkOutput("dut1_y", m_y1, e.y);
          checkOutput("dut1_z", m_z1, e.z);
          checkOutput("dut1_tag", m_tag1, e.tag);
          if (!seen1) checkOutput("dut1_latency", cycle - e.accept_cycle + 1, 4);
        end
      end
      if (m_valid2) begin
        if (q2.size() == 0) checkOutput("dut2_unexpected_valid", 1, 0);
        else begin
          e = q2.pop_front();
          checkOutput("dut2_x_sat", m_x2, e.x);
          checkOutput("dut2_y", m_y2, e.y);
          checkOutput("dut2_behind", m_behind2, e.behind);
          checkOutput("dut2_tag", m_tag2, e.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; cam_load = 1'b0; s_valid0 = 1'b0; s_valid1 = 1'b0;
    s_P0 = '0; s_P1 = '0; s_tag0 = '0; s_tag1 = '0;
    m_ready0 = 1'b1; m_ready1 = 1'b1;
    setCamInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    commitModelCam();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", m_valid0, 0);
    checkOutput("reset_m_x", m_x0, 0);
    checkOutput("reset_m_z", m_z0, 0);
    checkOutput("reset_m_behind", m_behind0, 0);
    checkOutput("reset_m_tag", m_tag0, 0);
    checkOutput("reset_s_ready_low", s_ready0, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_s_ready", s_ready0, 1);

    $display("[TB] identity camera");
    loadCamera(0, 0, 0, 16384, 0, 0, 0, 16384, 0, 0, 0, 16384);
    latency_check = 1'b1;
    applyStimulus(100, 200, 300, 8'd5, 1'b0);
    waitDrain();
    applyStimulus(-1234, 567, 32767, 8'd6, 1'b0);
    applyStimulus(-32768, 0, 1, 8'd7, 1'b0);
    waitDrain();

    $display("[TB] near plane");
    loadCamera(0, 0, 500, 16384, 0, 0, 0, 16384, 0, 0, 0, 16384);
    applyStimulus(0, 0, 300, 8'd8, 1'b0);
    applyStimulus(0, 0, 500, 8'd9, 1'b0);
    applyStimulus(0, 0, 501, 8'd10, 1'b0);
    waitDrain();

    $display("[TB] stream with backpressure");
    loadCamera(1000, -2000, 300, 11585, 0, -11585, 0, 16384, 0, 11585, 0, 11585);
    latency_check = 1'b0;
    fork
      begin
        for (int t = 0; t < 8; t++)
          applyStimulus(int'($urandom_range(60000)) - 30000, int'($urandom_range(60000)) - 30000,
                        int'($urandom_range(60000)) - 30000, 8'(t), 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 m_ready0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_ready0 = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] camera update mid-stream");
    loadCamera(0, 0, 0, 16384, 0, 0, 0, 16384, 0, 0, 0, 16384);
    latency_check = 1'b1;
    setCamInputs(10, 0, 0, 16384, 0, 0, 0, 16384, 0, 0, 0, 16384);
    for (int t = 0; t < 8; t++) begin
      applyStimulus(100 + t * 10, 20, 300, 8'(t + 16), t == 3);
      if (t == 3) checkOutput("cam_pend_blocks_s_ready", s_ready0, 0);
    end
    waitDrain();

    $display("[TB] reset mid-stream");
    applyStimulus(1, 2, 3, 8'd40, 1'b0);
    applyStimulus(4, 5, 6, 8'd41, 1'b0);
    applyStimulus(7, 8, 9, 8'd42, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_s_ready_low", s_ready0, 0);
    q0.delete(); q1.delete(); q2.delete();
    seen0 = 1'b0; seen1 = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_reset_m_valid", m_valid0, 0);
    rst = 1'b0;
    setCamInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    commitModelCam();
    loadCamera(0, 0, 0, 16384, 0, 0, 0, 16384, 0, 0, 0, 16384);
    applyStimulus(-50, 60, -70, 8'd43, 1'b0);
    waitDrain();

    $display("[TB] viewport scaling");
    applyStimulus1(1000, -300, 400, 8'd1);
    applyStimulus1(100, 0, 0, 8'd2);
    applyStimulus1(-100, 5, -5, 8'd3);
    applyStimulus1(-32768, 32767, 0, 8'd4);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
